// File: rtl/power_mode_sequencer.sv
// rtl/power_mode_sequencer.sv - panel power-mode sequencer in front of the bias MUX controller
//
// Steps the panel NORMAL -> IDLE_LOW -> SLEEP on inactivity and back on host or
// readout demand. Each mode change is handed to the bias controller through
// bias_mode_select and tracked over the busy/ready handshake. A stalled
// handshake latches a sticky fault.
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   frame_active      readout activity this cycle
//   wake_req          host request for NORMAL (level)
//   force_sleep       host request for SLEEP; beats any wake source
//   fault_clr         pulse that clears bias_fault and restarts toward NORMAL
//   bias_busy         bias controller: switch in progress
//   bias_ready        bias controller: bias settled
//   bias_mode_select  00 NORMAL, 01 IDLE_LOW, 10 SLEEP
//   power_state       0 NORMAL, 1 IDLE_LOW, 2 SLEEP, 3 WAIT_ACK, 4 WAIT_DONE, 5 FAULT
//   readout_enable    NORMAL and bias_ready
//   mode_done         one-cycle pulse on arrival in a requested mode
//   bias_fault        sticky handshake-timeout flag
module power_mode_sequencer #(
   parameter int IDLE_LOW_CYCLES = 1_000_000,
   parameter int SLEEP_CYCLES    = 100_000_000,
   parameter int ACK_TIMEOUT     = 16,
   parameter int DONE_TIMEOUT    = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_active,
   input  logic       wake_req,
   input  logic       force_sleep,
   input  logic       fault_clr,
   input  logic       bias_busy,
   input  logic       bias_ready,
   output logic [1:0] bias_mode_select,
   output logic [2:0] power_state,
   output logic       readout_enable,
   output logic       mode_done,
   output logic       bias_fault
);

   typedef enum logic [2:0] {
      ST_NORMAL    = 3'd0,
      ST_IDLE_LOW  = 3'd1,
      ST_SLEEP     = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   localparam logic [1:0]  SEL_NORMAL = 2'b00;
   localparam logic [1:0]  SEL_IDLE   = 2'b01;
   localparam logic [1:0]  SEL_SLEEP  = 2'b10;
   localparam logic [31:0] IDLE_LAST  = 32'(IDLE_LOW_CYCLES - 1);
   localparam logic [31:0] SLEEP_LAST = 32'(SLEEP_CYCLES - 1);
   localparam logic [31:0] ACK_LIM    = 32'(ACK_TIMEOUT);
   localparam logic [31:0] DONE_LIM   = 32'(DONE_TIMEOUT);

   state_t      state, state_nx;
   logic [1:0]  sel, sel_nx, issue_sel;
   logic [31:0] idle_cnt, idle_cnt_nx;
   logic [31:0] hs_cnt, hs_cnt_nx, hs_inc;
   logic        pend_sleep, pend_sleep_nx;
   logic        pend_wake, pend_wake_nx;
   logic        done_nx, fault_nx, issue;
   logic        sleep_req, wake_any;

   function automatic state_t steady_of(input logic [1:0] s);
      case (s)
         SEL_IDLE:  return ST_IDLE_LOW;
         SEL_SLEEP: return ST_SLEEP;
         default:   return ST_NORMAL;
      endcase
   endfunction

   // Pending flags only hold requests seen during a handshake; in a steady
   // state they are consumed on the first cycle after arrival.
   assign sleep_req = force_sleep | pend_sleep;
   assign wake_any  = (wake_req | frame_active | pend_wake) & ~force_sleep;
   assign hs_inc    = hs_cnt + 32'd1;

   always_comb begin
      state_nx      = state;
      sel_nx        = sel;
      idle_cnt_nx   = idle_cnt;
      hs_cnt_nx     = hs_cnt;
      pend_sleep_nx = pend_sleep;
      pend_wake_nx  = pend_wake;
      done_nx       = 1'b0;
      fault_nx      = bias_fault;
      issue         = 1'b0;
      issue_sel     = SEL_NORMAL;

      case (state)
         ST_NORMAL, ST_IDLE_LOW, ST_SLEEP: begin
            pend_sleep_nx = 1'b0;
            pend_wake_nx  = 1'b0;
            if (sleep_req && state != ST_SLEEP) begin
               issue     = 1'b1;
               issue_sel = SEL_SLEEP;
            end else if (wake_any && state != ST_NORMAL) begin
               issue     = 1'b1;
               issue_sel = SEL_NORMAL;
            end else if (!frame_active && state == ST_NORMAL && idle_cnt == IDLE_LAST) begin
               issue     = 1'b1;
               issue_sel = SEL_IDLE;
            end else if (!frame_active && state == ST_IDLE_LOW && idle_cnt == SLEEP_LAST) begin
               issue     = 1'b1;
               issue_sel = SEL_SLEEP;
            end
            if (frame_active)
               idle_cnt_nx = 32'd0;
            else if (idle_cnt != 32'hFFFF_FFFF)
               idle_cnt_nx = idle_cnt + 32'd1;
         end

         ST_WAIT_ACK: begin
            pend_sleep_nx = pend_sleep | force_sleep;
            pend_wake_nx  = pend_wake | wake_req | frame_active;
            if (bias_busy) begin
               state_nx  = ST_WAIT_DONE;
               hs_cnt_nx = 32'd0;
            end else if (hs_inc == ACK_LIM) begin
               state_nx = ST_FAULT;
               fault_nx = 1'b1;
            end else begin
               hs_cnt_nx = hs_inc;
            end
         end

         ST_WAIT_DONE: begin
            pend_sleep_nx = pend_sleep | force_sleep;
            pend_wake_nx  = pend_wake | wake_req | frame_active;
            if (!bias_busy && bias_ready) begin
               state_nx    = steady_of(sel);
               done_nx     = 1'b1;
               idle_cnt_nx = 32'd0;
            end else if (hs_inc == DONE_LIM) begin
               state_nx = ST_FAULT;
               fault_nx = 1'b1;
            end else begin
               hs_cnt_nx = hs_inc;
            end
         end

         ST_FAULT: begin
            if (fault_clr) begin
               fault_nx  = 1'b0;
               issue     = 1'b1;
               issue_sel = SEL_NORMAL;
            end
         end

         default: state_nx = ST_NORMAL;
      endcase

      if (issue) begin
         state_nx  = ST_WAIT_ACK;
         sel_nx    = issue_sel;
         hs_cnt_nx = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_NORMAL;
         sel        <= SEL_NORMAL;
         idle_cnt   <= 32'd0;
         hs_cnt     <= 32'd0;
         pend_sleep <= 1'b0;
         pend_wake  <= 1'b0;
         mode_done  <= 1'b0;
         bias_fault <= 1'b0;
      end else begin
         state      <= state_nx;
         sel        <= sel_nx;
         idle_cnt   <= idle_cnt_nx;
         hs_cnt     <= hs_cnt_nx;
         pend_sleep <= pend_sleep_nx;
         pend_wake  <= pend_wake_nx;
         mode_done  <= done_nx;
         bias_fault <= fault_nx;
      end
   end

   assign bias_mode_select = sel;
   assign power_state      = state;
   assign readout_enable   = (state == ST_NORMAL) && bias_ready;

endmodule

// File: tb/tb_power_mode_sequencer.sv
// tb/tb_power_mode_sequencer.sv - randomized scoreboard bench for power_mode_sequencer
module tb_power_mode_sequencer;
   localparam int IDLE_N  = 8;
   localparam int SLEEP_N = 16;
   localparam int ACK_N   = 4;
   localparam int DONE_N  = 20;
   localparam int NEVER   = 100000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_active = 1'b0;
   logic       wake_req = 1'b0;
   logic       force_sleep = 1'b0;
   logic       fault_clr = 1'b0;
   logic       bias_busy = 1'b0;
   logic       bias_ready = 1'b1;
   logic [1:0] bias_mode_select;
   logic [2:0] power_state;
   logic       readout_enable;
   logic       mode_done;
   logic       bias_fault;

   always #5 clk = ~clk;

   power_mode_sequencer #(
      .IDLE_LOW_CYCLES(IDLE_N),
      .SLEEP_CYCLES   (SLEEP_N),
      .ACK_TIMEOUT    (ACK_N),
      .DONE_TIMEOUT   (DONE_N)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .frame_active    (frame_active),
      .wake_req        (wake_req),
      .force_sleep     (force_sleep),
      .fault_clr       (fault_clr),
      .bias_busy       (bias_busy),
      .bias_ready      (bias_ready),
      .bias_mode_select(bias_mode_select),
      .power_state     (power_state),
      .readout_enable  (readout_enable),
      .mode_done       (mode_done),
      .bias_fault      (bias_fault)
   );

   typedef struct packed {
      logic [1:0] sel;
      logic [2:0] st;
      logic       done;
      logic       fault;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: timestamps instead of counters.
   // phase: 0 settled in m_mode, 1 awaiting ack, 2 awaiting settle, 3 faulted
   int cyc = 0;
   int m_phase = 0, m_mode = 0, m_sel = 0;
   int m_quiet = 0;     // cycle at which the quiet run began
   int m_t0 = 0;        // first cycle of the current handshake phase
   int m_reissue = -1;  // target queued by pending requests at arrival
   bit m_ps = 0, m_pw = 0, m_fault = 0, m_done = 0, m_issued = 0;

   task automatic model_issue(input int tgt);
      m_sel    = tgt;
      m_phase  = 1;
      m_t0     = cyc + 1;
      m_issued = 1;
   endtask

   task automatic model_step();
      bit fa = frame_active;
      bit wk = wake_req;
      bit fs = force_sleep;
      int tgt;
      tgt      = -1;
      m_done   = 0;
      m_issued = 0;
      if (rst) begin
         m_phase = 0; m_mode = 0; m_sel = 0; m_quiet = cyc + 1;
         m_ps = 0; m_pw = 0; m_reissue = -1; m_fault = 0;
      end else begin
         case (m_phase)
            0: begin
               if (m_reissue == 2) tgt = 2;
               else if (fs && m_mode != 2) tgt = 2;
               else if (!fs && (m_reissue == 0 || ((wk || fa) && m_mode != 0))) tgt = 0;
               else if (!fa && m_mode == 0 && cyc - m_quiet == IDLE_N - 1) tgt = 1;
               else if (!fa && m_mode == 1 && cyc - m_quiet == SLEEP_N - 1) tgt = 2;
               m_reissue = -1;
               if (fa) m_quiet = cyc + 1;
               if (tgt >= 0) model_issue(tgt);
            end
            1: begin
               m_ps = m_ps | fs;
               m_pw = m_pw | wk | fa;
               if (bias_busy) begin
                  m_phase = 2;
                  m_t0    = cyc + 1;
               end else if (cyc - m_t0 + 1 == ACK_N) begin
                  m_phase = 3;
                  m_fault = 1;
               end
            end
            2: begin
               m_ps = m_ps | fs;
               m_pw = m_pw | wk | fa;
               if (!bias_busy && bias_ready) begin
                  m_phase   = 0;
                  m_mode    = m_sel;
                  m_done    = 1;
                  m_quiet   = cyc + 1;
                  m_reissue = (m_ps && m_sel != 2) ? 2 : ((m_pw && m_sel != 0) ? 0 : -1);
                  m_ps      = 0;
                  m_pw      = 0;
               end else if (cyc - m_t0 + 1 == DONE_N) begin
                  m_phase = 3;
                  m_fault = 1;
               end
            end
            default: begin
               if (fault_clr) begin
                  m_fault = 0;
                  model_issue(0);
               end
            end
         endcase
      end
   endtask

   // Bias controller stand-in, driven by the model's issue events.
   int b_age = 0, b_ack = 2, b_len = 1;
   bit b_active = 0;
   int ack_mode = 0, len_mode = 0, ready_glitch = 0;

   task automatic bias_update();
      if (rst) begin
         b_active   = 0;
         bias_busy  = 1'b0;
         bias_ready = 1'b1;
      end else begin
         if (m_issued) begin
            b_active = 1;
            b_age    = 0;
            case (ack_mode)
               0: b_ack = $urandom_range(2, 3);
               1: b_ack = $urandom_range(2, 5);
               2: b_ack = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(2, 3);
               default: b_ack = NEVER;
            endcase
            b_len = (len_mode == 0) ? $urandom_range(1, 10) : $urandom_range(17, 23);
         end else if (b_active) begin
            b_age++;
         end
         if (b_active) begin
            if (b_age < b_ack) begin
               bias_busy = 1'b0;
            end else if (b_age < b_ack + b_len) begin
               bias_busy  = 1'b1;
               bias_ready = 1'b0;
            end else begin
               bias_busy  = 1'b0;
               bias_ready = 1'b1;
               b_active   = 0;
            end
         end else begin
            bias_busy  = 1'b0;
            bias_ready = (ready_glitch != 0 && $urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
         end
      end
   endtask

   // Monitor: one expected record per cycle, compared away from the active edge.
   int   mon_cyc = 0;
   exp_t e;
   logic exp_ro;
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e      = exp_q.pop_front();
            exp_ro = (e.st == 3'd0) && bias_ready;
            vectors++;
            if ({bias_mode_select, power_state, mode_done, bias_fault} !== e ||
                readout_enable !== exp_ro) begin
               miscompares++;
               $display("FAIL outputs cycle %0d: got sel=%b state=%0d done=%b fault=%b ro=%b, expected sel=%b state=%0d done=%b fault=%b ro=%b",
                        mon_cyc, bias_mode_select, power_state, mode_done, bias_fault, readout_enable,
                        e.sel, e.st, e.done, e.fault, exp_ro);
            end
         end
         mon_cyc++;
      end
   end

   int p_frame, p_wake, p_force, p_clr;
   bit cfg_rst;
   exp_t x;

   initial begin
      for (int seg = 0; seg < 60; seg++) begin
         if (seg < 2) begin
            p_frame = 0; p_wake = 0; p_force = 0; p_clr = 0; cfg_rst = 0;
            ack_mode = 0; len_mode = 0; ready_glitch = 0;
         end else begin
            case ($urandom_range(0, 3))
               0: p_frame = 0;
               1: p_frame = 1;
               2: p_frame = 5;
               default: p_frame = 30;
            endcase
            p_wake       = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8);
            p_force      = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8);
            p_clr        = ($urandom_range(0, 1) == 0) ? 0 : 20;
            cfg_rst      = (seg % 5 == 4);
            ack_mode     = $urandom_range(0, 3);
            len_mode     = $urandom_range(0, 1);
            ready_glitch = $urandom_range(0, 1);
         end
         for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            model_step();
            x.sel   = 2'(m_sel);
            x.st    = (m_phase == 0) ? 3'(m_mode) : 3'(m_phase + 2);
            x.done  = m_done;
            x.fault = m_fault;
            exp_q.push_back(x);
            bias_update();
            rst          = (seg == 0 && k < 3) || (cfg_rst && $urandom_range(0, 149) == 0);
            frame_active = ($urandom_range(0, 99) < p_frame);
            wake_req     = ($urandom_range(0, 99) < p_wake);
            force_sleep  = ($urandom_range(0, 99) < p_force);
            fault_clr    = ($urandom_range(0, 99) < p_clr);
            cyc++;
         end
      end
      rst = 1'b0; frame_active = 1'b0; wake_req = 1'b0; force_sleep = 1'b0; fault_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard drain: %0d expected records left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
